// File: rtl/ps2_pkg.sv
// Shared PS/2 set-2 scan constants and fetch-state encoding for the scan decoder.
package ps2_pkg;
    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_BAT    = 8'hAA;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_PAUSE  = 8'hE1;
    localparam logic [7:0] PS2_ERR0   = 8'h00;
    localparam logic [7:0] PS2_ERRF   = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POP  = 2'd1,
        ST_GAP  = 2'd2
    } fetch_st_e;

    // Controller chatter that carries no key information when seen bare.
    function automatic logic ps2_is_noise(input logic [7:0] b);
        return (b == PS2_ERR0) || (b == PS2_ERRF) || (b == PS2_BAT) ||
               (b == PS2_ACK)  || (b == PS2_RESEND) || (b == PS2_ECHO) ||
               (b == PS2_PAUSE);
    endfunction
endpackage

// File: rtl/ps2_held_key.sv
// Tracks the currently held key, flags typematic repeats and counts fresh presses.
module ps2_held_key #(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               evt_i,
    input  logic [7:0]         code_i,
    input  logic               ext_i,
    input  logic               rel_i,
    output logic               repeat_o,
    output logic               down_o,
    output logic [COUNT_W-1:0] count_o
);
    logic [7:0]         held_code_q, held_code_d;
    logic               held_ext_q, held_ext_d;
    logic               down_q, down_d;
    logic               repeat_q, repeat_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               match;

    assign match = (code_i == held_code_q) && (ext_i == held_ext_q);

    always_comb begin
        held_code_d = held_code_q;
        held_ext_d  = held_ext_q;
        down_d      = down_q;
        repeat_d    = repeat_q;
        count_d     = count_q;
        if (evt_i) begin
            repeat_d = 1'b0;
            if (!rel_i) begin
                if (down_q && match) begin
                    repeat_d = 1'b1;
                end else begin
                    // First press or rollover: the new key replaces whatever was held.
                    held_code_d = code_i;
                    held_ext_d  = ext_i;
                    down_d      = 1'b1;
                    count_d     = count_q + 1'b1;
                end
            end else if (match) begin
                down_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_code_q <= 8'h00;
            held_ext_q  <= 1'b0;
            down_q      <= 1'b0;
            repeat_q    <= 1'b0;
            count_q     <= '0;
        end else begin
            held_code_q <= held_code_d;
            held_ext_q  <= held_ext_d;
            down_q      <= down_d;
            repeat_q    <= repeat_d;
            count_q     <= count_d;
        end
    end

    assign repeat_o = repeat_q;
    assign down_o   = down_q;
    assign count_o  = count_q;
endmodule

// File: rtl/ps2_scan_decoder.sv
// Pops bytes from the PS/2 keyboard FIFO, strips E0/F0 prefixes and emits one event per key.
module ps2_scan_decoder
    import ps2_pkg::*;
#(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ready,
    input  logic [7:0]         data,
    input  logic               overflow,
    output logic               nextdata_n,
    output logic               key_valid,
    output logic [7:0]         key_code,
    output logic               key_ext,
    output logic               key_release,
    output logic               key_repeat,
    output logic               key_down,
    output logic [COUNT_W-1:0] press_count,
    output logic               ovf_seen
);
    fetch_st_e  state_q, state_d;
    logic       ext_pend_q, ext_pend_d;
    logic       brk_pend_q, brk_pend_d;
    logic       key_valid_q;
    logic [7:0] key_code_q, key_code_d;
    logic       key_ext_q, key_ext_d;
    logic       key_release_q, key_release_d;
    logic       ovf_seen_q;
    logic       take, is_noise, evt;

    // The byte is decoded as it is latched, so every registered output is already
    // updated during the POP cycle, coincident with the pop strobe.
    assign take     = (state_q == ST_IDLE) && ready;
    assign is_noise = ps2_is_noise(data) && !ext_pend_q && !brk_pend_q;
    assign evt      = take && !is_noise && (data != PS2_EXT) && (data != PS2_BRK);

    always_comb begin
        state_d       = state_q;
        nextdata_n    = 1'b1;
        ext_pend_d    = ext_pend_q;
        brk_pend_d    = brk_pend_q;
        key_code_d    = key_code_q;
        key_ext_d     = key_ext_q;
        key_release_d = key_release_q;
        case (state_q)
            ST_IDLE: if (ready) state_d = ST_POP;
            ST_POP: begin
                nextdata_n = 1'b0;
                state_d    = ST_GAP;
            end
            default: state_d = ST_IDLE;
        endcase
        if (take) begin
            if (data == PS2_EXT) begin
                ext_pend_d = 1'b1;
            end else if (data == PS2_BRK) begin
                brk_pend_d = 1'b1;
            end else if (evt) begin
                key_code_d    = data;
                key_ext_d     = ext_pend_q;
                key_release_d = brk_pend_q;
                ext_pend_d    = 1'b0;
                brk_pend_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            ext_pend_q    <= 1'b0;
            brk_pend_q    <= 1'b0;
            key_valid_q   <= 1'b0;
            key_code_q    <= 8'h00;
            key_ext_q     <= 1'b0;
            key_release_q <= 1'b0;
            ovf_seen_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            ext_pend_q    <= ext_pend_d;
            brk_pend_q    <= brk_pend_d;
            key_valid_q   <= evt;
            key_code_q    <= key_code_d;
            key_ext_q     <= key_ext_d;
            key_release_q <= key_release_d;
            ovf_seen_q    <= ovf_seen_q | overflow;
        end
    end

    ps2_held_key #(.COUNT_W(COUNT_W)) u_held (
        .clk      (clk),
        .rst      (rst),
        .evt_i    (evt),
        .code_i   (data),
        .ext_i    (ext_pend_q),
        .rel_i    (brk_pend_q),
        .repeat_o (key_repeat),
        .down_o   (key_down),
        .count_o  (press_count)
    );

    assign key_valid   = key_valid_q;
    assign key_code    = key_code_q;
    assign key_ext     = key_ext_q;
    assign key_release = key_release_q;
    assign ovf_seen    = ovf_seen_q;
endmodule
